// File: rtl/sigdel_pkg.sv
// Shared definitions for the virtualized sigma-delta bank: feedback levels,
// loop-order encoding and the saturating add used when SIGDEL_INTEGRATOR_SATURATION_EN is set.
package sigdel_pkg;

    typedef enum logic {
        ORDER_FIRST  = 1'b0,
        ORDER_SECOND = 1'b1
    } order_e;

    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic wide_t full_pos(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t full_neg(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    // Symmetric clamp: the most negative code is never produced.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
        wide_t lim;
        wide_t s;
        lim = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        s   = a + b;
        if (s > lim)
            return lim;
        if (s < -lim)
            return -lim;
        return s;
    endfunction

endpackage

// File: rtl/sigdel_loop_core.sv
// Combinational single-channel sigma-delta update (first or second order).
// SIGDEL_INTEGRATOR_SATURATION_EN selects clamping instead of two's-complement wrap.
module sigdel_loop_core
    import sigdel_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int GUARD = 4
) (
    input  logic signed [IN_W-1:0]       x_i,
    input  logic signed [IN_W+GUARD-1:0] i1_i,
    input  logic signed [IN_W+GUARD-1:0] i2_i,
    input  logic                         b_i,
    input  logic                         order_i,
    output logic signed [IN_W+GUARD-1:0] i1_o,
    output logic signed [IN_W+GUARD-1:0] i2_o,
    output logic                         b_o
);

    localparam int ACC_W = IN_W + GUARD;

    wide_t                   fb;
    wide_t                   sum1;
    wide_t                   sum2;
    logic signed [ACC_W-1:0] i1_n;
    logic signed [ACC_W-1:0] i2_n;

    always_comb begin
        fb   = b_i ? full_pos(IN_W) : full_neg(IN_W);
        sum1 = wide_t'(x_i) + wide_t'(i1_i);
`ifdef SIGDEL_INTEGRATOR_SATURATION_EN
        i1_n = ACC_W'(sat_add(sum1, -fb, ACC_W));
        sum2 = wide_t'(i2_i) + wide_t'(i1_n);
        i2_n = ACC_W'(sat_add(sum2, -fb, ACC_W));
`else
        i1_n = ACC_W'(sum1 - fb);
        sum2 = wide_t'(i2_i) + wide_t'(i1_n);
        i2_n = ACC_W'(sum2 - fb);
`endif
        i1_o = i1_n;
        if (order_i == ORDER_SECOND) begin
            i2_o = i2_n;
            b_o  = ~i2_n[ACC_W-1];
        end else begin
            i2_o = '0;
            b_o  = ~i1_n[ACC_W-1];
        end
    end

endmodule

// File: rtl/sigdel_virtualized_multi.sv
// Time-multiplexed sigma-delta modulator bank: CHANNELS virtual loops share one
// sigdel_loop_core. Build option: SIGDEL_INTEGRATOR_SATURATION_EN (clamp integrators).
module sigdel_virtualized_multi
    import sigdel_pkg::*;
#(
    parameter int CHANNELS = 10,
    parameter int IN_W     = 24,
    parameter int GUARD    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mod_enable,
    input  logic                          write_enable,
    input  logic [$clog2(CHANNELS)-1:0]   write_address,
    input  logic [IN_W-1:0]               write_data,
    input  logic                          write_order,
    input  logic [$clog2(CHANNELS)-1:0]   log_address,
    output logic                          log_bitstream,
    output logic [IN_W+GUARD-1:0]         log_integrator,
    output logic [CHANNELS-1:0]           bitstream_reg,
    output logic [$clog2(CHANNELS)-1:0]   active_channel,
    output logic                          frame_strobe
);

    localparam int             ACC_W  = IN_W + GUARD;
    localparam int             AW     = $clog2(CHANNELS);
    localparam logic [AW-1:0]  LAST   = AW'(CHANNELS - 1);
    localparam logic [AW:0]    CH_CNT = (AW + 1)'(CHANNELS);

    logic signed [IN_W-1:0]  x_q  [CHANNELS];
    logic signed [IN_W-1:0]  x_d  [CHANNELS];
    logic signed [ACC_W-1:0] i1_q [CHANNELS];
    logic signed [ACC_W-1:0] i1_d [CHANNELS];
    logic signed [ACC_W-1:0] i2_q [CHANNELS];
    logic signed [ACC_W-1:0] i2_d [CHANNELS];
    logic [CHANNELS-1:0]     ord_q, ord_d;
    logic [CHANNELS-1:0]     b_q, b_d;
    logic [AW-1:0]           act_q, act_d;
    logic                    strobe_q, strobe_d;
    logic                    log_bit_q, log_bit_d;
    logic [ACC_W-1:0]        log_int_q, log_int_d;

    logic signed [ACC_W-1:0] core_i1, core_i2;
    logic                    core_b;
    logic                    wr_hit;

    sigdel_loop_core #(
        .IN_W  (IN_W),
        .GUARD (GUARD)
    ) u_core (
        .x_i     (x_q[act_q]),
        .i1_i    (i1_q[act_q]),
        .i2_i    (i2_q[act_q]),
        .b_i     (b_q[act_q]),
        .order_i (ord_q[act_q]),
        .i1_o    (core_i1),
        .i2_o    (core_i2),
        .b_o     (core_b)
    );

    assign wr_hit = write_enable && ({1'b0, write_address} < CH_CNT);

    // Processing is applied first; a write that flips the order then clears the
    // same channel, so the clear wins while the update still used the old sample.
    always_comb begin
        x_d   = x_q;
        i1_d  = i1_q;
        i2_d  = i2_q;
        ord_d = ord_q;
        b_d   = b_q;
        if (mod_enable) begin
            i1_d[act_q] = core_i1;
            i2_d[act_q] = core_i2;
            b_d[act_q]  = core_b;
        end
        if (wr_hit) begin
            x_d[write_address]   = write_data;
            ord_d[write_address] = write_order;
            if (write_order != ord_q[write_address]) begin
                i1_d[write_address] = '0;
                i2_d[write_address] = '0;
                b_d[write_address]  = 1'b0;
            end
        end
    end

    always_comb begin
        act_d    = act_q;
        strobe_d = 1'b0;
        if (mod_enable) begin
            act_d    = (act_q == LAST) ? '0 : act_q + AW'(1);
            strobe_d = (act_q == LAST);
        end
    end

    always_comb begin
        log_bit_d = 1'b0;
        log_int_d = '0;
        if ({1'b0, log_address} < CH_CNT) begin
            log_bit_d = b_q[log_address];
            log_int_d = ord_q[log_address] ? i2_q[log_address] : i1_q[log_address];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                x_q[c]  <= '0;
                i1_q[c] <= '0;
                i2_q[c] <= '0;
            end
            ord_q     <= '0;
            b_q       <= '0;
            act_q     <= '0;
            strobe_q  <= 1'b0;
            log_bit_q <= 1'b0;
            log_int_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                x_q[c]  <= x_d[c];
                i1_q[c] <= i1_d[c];
                i2_q[c] <= i2_d[c];
            end
            ord_q     <= ord_d;
            b_q       <= b_d;
            act_q     <= act_d;
            strobe_q  <= strobe_d;
            log_bit_q <= log_bit_d;
            log_int_q <= log_int_d;
        end
    end

    assign bitstream_reg  = b_q;
    assign active_channel = act_q;
    assign frame_strobe   = strobe_q;
    assign log_bitstream  = log_bit_q;
    assign log_integrator = log_int_q;

endmodule

// File: tb/tb_sigdel_virtualized_multi.sv
// Bench for sigdel_virtualized_multi: arithmetic reference model compared every
// cycle, plus literal pins and directed/random scenarios.
module tb_sigdel_virtualized_multi;

    localparam int     CH     = 10;
    localparam int     IN_W   = 24;
    localparam int     GUARD  = 4;
    localparam int     ACC_W  = IN_W + GUARD;
    localparam int     AW     = 4;
    localparam longint FPOS   = (64'sd1 <<< (IN_W - 1)) - 1;
    localparam longint FNEG   = -(64'sd1 <<< (IN_W - 1));
    localparam longint MODV   = 64'sd1 <<< ACC_W;
    localparam longint HALF   = 64'sd1 <<< (ACC_W - 1);
    localparam longint AMAX   = HALF - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              mod_enable;
    logic              write_enable;
    logic [AW-1:0]     write_address;
    logic [IN_W-1:0]   write_data;
    logic              write_order;
    logic [AW-1:0]     log_address;
    logic              log_bitstream;
    logic [ACC_W-1:0]  log_integrator;
    logic [CH-1:0]     bitstream_reg;
    logic [AW-1:0]     active_channel;
    logic              frame_strobe;

    sigdel_virtualized_multi #(.CHANNELS(CH), .IN_W(IN_W), .GUARD(GUARD)) dut (
        .clock          (clock),
        .reset          (reset),
        .mod_enable     (mod_enable),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_data     (write_data),
        .write_order    (write_order),
        .log_address    (log_address),
        .log_bitstream  (log_bitstream),
        .log_integrator (log_integrator),
        .bitstream_reg  (bitstream_reg),
        .active_channel (active_channel),
        .frame_strobe   (frame_strobe)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // reference model state
    longint m_x [CH];
    longint m_i1[CH];
    longint m_i2[CH];
    bit     m_ord[CH];
    bit     m_b [CH];
    int     m_act;
    bit     m_strobe;
    bit     m_logbit;
    longint m_logint;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint sx_acc(input logic [ACC_W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint fix(input longint v);
        longint r;
`ifdef SIGDEL_INTEGRATOR_SATURATION_EN
        r = v;
        if (r > AMAX) r = AMAX;
        if (r < -AMAX) r = -AMAX;
`else
        r = ((v % MODV) + MODV) % MODV;
        if (r >= HALF) r = r - MODV;
`endif
        return r;
    endfunction

    function automatic logic [CH-1:0] m_bits();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_b[c];
        return v;
    endfunction

    task automatic model_step();
        longint fb, n1, n2;
        bit nb;
        int a, wa, la;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_x[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_ord[c] = 0; m_b[c] = 0;
            end
            m_act = 0; m_strobe = 0; m_logbit = 0; m_logint = 0;
            return;
        end
        la = int'(log_address);
        if (la < CH) begin
            m_logbit = m_b[la];
            m_logint = m_ord[la] ? m_i2[la] : m_i1[la];
        end else begin
            m_logbit = 0;
            m_logint = 0;
        end
        m_strobe = mod_enable && (m_act == CH - 1);
        if (mod_enable) begin
            a  = m_act;
            fb = m_b[a] ? FPOS : FNEG;
            n1 = fix(m_i1[a] + m_x[a] - fb);
            if (m_ord[a]) begin
                n2 = fix(m_i2[a] + n1 - fb);
                nb = (n2 >= 0);
            end else begin
                n2 = 0;
                nb = (n1 >= 0);
            end
            m_i1[a] = n1; m_i2[a] = n2; m_b[a] = nb;
            m_act = (m_act + 1) % CH;
        end
        wa = int'(write_address);
        if (write_enable && wa < CH) begin
            if (write_order != m_ord[wa]) begin
                m_i1[wa] = 0; m_i2[wa] = 0; m_b[wa] = 0;
            end
            m_ord[wa] = write_order;
            m_x[wa]   = longint'($signed(write_data));
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("bitstream_reg", longint'(bitstream_reg), longint'(m_bits()));
            chk("active_channel", longint'(active_channel), longint'(m_act));
            chk("frame_strobe", longint'(frame_strobe), longint'(m_strobe));
            chk("log_bitstream", longint'(log_bitstream), longint'(m_logbit));
            chk("log_integrator", sx_acc(log_integrator), m_logint);
        end
    end

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_write(input int addr, input longint data, input bit ord);
        write_enable  = 1'b1;
        write_address = AW'(addr);
        write_data    = IN_W'(data);
        write_order   = ord;
        cycle();
        write_enable  = 1'b0;
    endtask

    task automatic wait_active(input int target);
        for (int k = 0; k < 2 * CH && int'(active_channel) != target; k++) cycle();
        chk("reach_active", longint'(active_channel), longint'(target));
    endtask

    int     ones_dut[CH];
    int     ones_mod[CH];
    int     frames;
    longint lmin, lmax;
    logic [CH-1:0] snap;

    initial begin
        reset = 1'b1; mod_enable = 1'b0; write_enable = 1'b0;
        write_address = '0; write_data = '0; write_order = 1'b0; log_address = 4'd3;

        cycle();
        chk_on = 1'b1;
        cycle();
        cycle();
        chk("rst_bitstream", longint'(bitstream_reg), 0);
        chk("rst_active", longint'(active_channel), 0);
        chk("rst_strobe", longint'(frame_strobe), 0);
        chk("rst_logbit", longint'(log_bitstream), 0);
        chk("rst_logint", sx_acc(log_integrator), 0);

        // release: channel 3 first order with x=0, logged
        reset = 1'b0; mod_enable = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            cycle();
            if (n == 9)  chk("strobe_n9", longint'(frame_strobe), 0);
            if (n == 10) chk("strobe_n10", longint'(frame_strobe), 1);
            if (n == 11) chk("strobe_n11", longint'(frame_strobe), 0);
            if (n == 20) chk("strobe_n20", longint'(frame_strobe), 1);
            if (n == 4)  chk("ch3_bit1", longint'(bitstream_reg[3]), 1);
            if (n == 14) chk("ch3_bit2", longint'(bitstream_reg[3]), 1);
            if (n == 24) chk("ch3_bit3", longint'(bitstream_reg[3]), 0);
            if (n == 5)  chk("ch3_log1", sx_acc(log_integrator), 8388608);
            if (n == 15) chk("ch3_log2", sx_acc(log_integrator), 1);
            if (n == 25) chk("ch3_log3", sx_acc(log_integrator), -8388606);
        end

        // channel 7 full positive, second order; density over 256 frames
        do_write(7, FPOS, 1'b1);
        for (int c = 0; c < CH; c++) begin ones_dut[c] = 0; ones_mod[c] = 0; end
        frames = 0;
        for (int k = 0; k < 2700 && frames < 256; k++) begin
            cycle();
            if (frame_strobe) begin
                frames++;
                for (int c = 0; c < CH; c++) begin
                    ones_dut[c] += int'(bitstream_reg[c]);
                    ones_mod[c] += int'(m_b[c]);
                end
            end
        end
        chk("frames_seen", longint'(frames), 256);
        chk("ch7_ones_model", longint'(ones_dut[7]), longint'(ones_mod[7]));
`ifdef SIGDEL_INTEGRATOR_SATURATION_EN
        chk("ch7_ones_ge99pct", longint'(ones_dut[7] >= 254), 1);
`endif
        for (int c = 0; c < CH; c++) begin
            if (c != 7)
                chk("idle_density", longint'(ones_dut[c] >= 123 && ones_dut[c] <= 133), 1);
        end

        // pause at channel 4
        wait_active(4);
        mod_enable = 1'b0;
        snap = bitstream_reg;
        for (int k = 0; k < 7; k++) begin
            cycle();
            chk("pause_active", longint'(active_channel), 4);
            chk("pause_bits", longint'(bitstream_reg), longint'(snap));
        end
        mod_enable = 1'b1;
        cycle();
        chk("resume_active", longint'(active_channel), 5);

        // channel 5 second order, then order flip on its processing edge
        do_write(5, 3000000, 1'b1);
        log_address = 4'd5;
        for (int k = 0; k < 47; k++) cycle();
        wait_active(5);
        do_write(5, 0, 1'b0);
        chk("flip_bit5", longint'(bitstream_reg[5]), 0);
        cycle();
        chk("flip_logint", sx_acc(log_integrator), 0);
        chk("flip_logbit", longint'(log_bitstream), 0);

        // channel 2 full negative, second order, 4096 frames
        do_write(2, FNEG, 1'b1);
        log_address = 4'd2;
        lmin = 0; lmax = 0;
        for (int k = 0; k < 4096 * CH; k++) begin
            cycle();
            if (sx_acc(log_integrator) < lmin) lmin = sx_acc(log_integrator);
            if (sx_acc(log_integrator) > lmax) lmax = sx_acc(log_integrator);
        end
`ifdef SIGDEL_INTEGRATOR_SATURATION_EN
        chk("sat_min_bound", longint'(lmin >= -AMAX), 1);
        chk("sat_max_bound", longint'(lmax <= AMAX), 1);
`endif

        // random traffic, including out-of-range addresses and a mid-frame reset
        for (int k = 0; k < 2000; k++) begin
            mod_enable    = ($urandom_range(0, 9) != 0);
            write_enable  = ($urandom_range(0, 3) == 0);
            write_address = AW'($urandom_range(0, 15));
            write_data    = IN_W'($urandom);
            write_order   = 1'($urandom_range(0, 1));
            log_address   = AW'($urandom_range(0, 15));
            reset         = (k == 1003);
            cycle();
        end
        reset = 1'b0; write_enable = 1'b0;
        cycle();
        chk_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
